// File: rtl/wb_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_timer : Wishbone-mapped prescaled compare timer with match/ovf irq    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module wb_timer #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [WB_ADDR_WIDTH-1:0] adr_i,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  input  logic [3:0]               sel_i,
  input  logic                     we_i,
  input  logic                     cyc_i,
  input  logic                     stb_i,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  output logic                     ack_o,
  output logic                     err_o,
  output logic                     irq_o,
  output logic                     tick_o
);

  localparam logic [9:0] c_IDX_CTRL     = 10'd0;
  localparam logic [9:0] c_IDX_PRESCALE = 10'd1;
  localparam logic [9:0] c_IDX_COUNT    = 10'd2;
  localparam logic [9:0] c_IDX_COMPARE  = 10'd3;
  localparam logic [9:0] c_IDX_STATUS   = 10'd4;

  logic        r_en, r_periodic, r_ie_match, r_ie_ovf;
  logic        r_match, r_ovf;
  logic [31:0] r_prescale, r_count, r_compare, r_pcnt;
  logic [31:0] r_dat;
  logic        r_ack, r_err, r_tick;

  logic        w_req, w_mapped, w_wr;
  logic        w_wr_ctrl, w_wr_prescale, w_wr_count, w_wr_compare, w_wr_status;
  logic        w_tick, w_tick_eff, w_match, w_wrap, w_oneshot_stop;
  logic [9:0]  w_idx;
  logic [31:0] w_rdata;
  logic        w_unused_adr;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[b*8 +: 8] = sel[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    return res;
  endfunction

  assign w_unused_adr = ^adr_i;
  assign w_idx        = adr_i[11:2];
  assign w_req        = cyc_i & stb_i & ~r_ack & ~r_err;
  assign w_mapped     = (w_idx <= c_IDX_STATUS);
  assign w_wr         = w_req & we_i & w_mapped;

  assign w_wr_ctrl     = w_wr & (w_idx == c_IDX_CTRL) & sel_i[0];
  assign w_wr_prescale = w_wr & (w_idx == c_IDX_PRESCALE);
  assign w_wr_count    = w_wr & (w_idx == c_IDX_COUNT) & (|sel_i);
  assign w_wr_compare  = w_wr & (w_idx == c_IDX_COMPARE);
  assign w_wr_status   = w_wr & (w_idx == c_IDX_STATUS) & sel_i[0];

  // A software COUNT write swallows a coincident tick entirely.
  assign w_tick         = r_en & (r_pcnt == r_prescale);
  assign w_tick_eff     = w_tick & ~w_wr_count;
  assign w_match        = w_tick_eff & (r_count == r_compare);
  assign w_wrap         = w_tick_eff & ~w_match & (r_count == 32'hFFFF_FFFF);
  assign w_oneshot_stop = w_match & ~r_periodic;

  always_comb begin
    w_rdata = 32'd0;
    case (w_idx)
      c_IDX_CTRL:     w_rdata = {28'd0, r_ie_ovf, r_ie_match, r_periodic, r_en};
      c_IDX_PRESCALE: w_rdata = r_prescale;
      c_IDX_COUNT:    w_rdata = r_count;
      c_IDX_COMPARE:  w_rdata = r_compare;
      c_IDX_STATUS:   w_rdata = {30'd0, r_ovf, r_match};
      default:        w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_en       <= 1'b0;
      r_periodic <= 1'b0;
      r_ie_match <= 1'b0;
      r_ie_ovf   <= 1'b0;
      r_match    <= 1'b0;
      r_ovf      <= 1'b0;
      r_prescale <= 32'd0;
      r_count    <= 32'd0;
      r_compare  <= 32'd0;
      r_pcnt     <= 32'd0;
      r_dat      <= 32'd0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      r_ack  <= w_req & w_mapped;
      r_err  <= w_req & ~w_mapped;
      r_dat  <= (w_req & ~we_i & w_mapped) ? w_rdata : 32'd0;
      r_tick <= w_match;

      if (w_wr_ctrl)
        {r_ie_ovf, r_ie_match, r_periodic, r_en} <= dat_i[3:0];
      if (w_oneshot_stop)
        r_en <= 1'b0;

      if (!r_en || (w_wr_ctrl && !dat_i[0]) || w_tick)
        r_pcnt <= 32'd0;
      else
        r_pcnt <= r_pcnt + 32'd1;

      if (w_wr_prescale)
        r_prescale <= f_merge(r_prescale, dat_i[31:0], sel_i);
      if (w_wr_compare)
        r_compare <= f_merge(r_compare, dat_i[31:0], sel_i);

      if (w_wr_count)
        r_count <= f_merge(r_count, dat_i[31:0], sel_i);
      else if (w_match)
        r_count <= 32'd0;
      else if (w_tick_eff)
        r_count <= r_count + 32'd1;

      // Hardware set dominates a same-edge W1C.
      r_match <= (r_match & ~(w_wr_status & dat_i[0])) | w_match;
      r_ovf   <= (r_ovf   & ~(w_wr_status & dat_i[1])) | w_wrap;
    end
  end

  assign dat_o  = r_dat;
  assign ack_o  = r_ack;
  assign err_o  = r_err;
  assign tick_o = r_tick;
  assign irq_o  = (r_match & r_ie_match) | (r_ovf & r_ie_ovf);

endmodule
`default_nettype wire

// File: tb/tb_wb_timer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb_timer : directed self-checking bench for wb_timer                  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_wb_timer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] adr_i;
  logic [31:0] dat_i;
  logic [3:0]  sel_i;
  logic        we_i, cyc_i, stb_i;
  logic [31:0] dat_o;
  logic        ack_o, err_o, irq_o, tick_o;

  int n_cmp = 0;
  int n_err = 0;

  wb_timer #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .adr_i(adr_i), .dat_i(dat_i), .sel_i(sel_i),
    .we_i(we_i), .cyc_i(cyc_i), .stb_i(stb_i),
    .dat_o(dat_o), .ack_o(ack_o), .err_o(err_o),
    .irq_o(irq_o), .tick_o(tick_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i); #1;
    end
  endtask

  // Waits out a pending ack/err, presents one request, returns #1 after the accepting edge.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd,
                     output logic ak, output logic er);
    @(negedge clk_i);
    if (ack_o || err_o) @(negedge clk_i);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = w; adr_i = a; dat_i = d; sel_i = s;
    @(posedge clk_i); #1;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; adr_i = '0; dat_i = '0; sel_i = '0;
    rd = dat_o; ak = ack_o; er = err_o;
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    logic [31:0] rd;
    logic ak, er;
    bus(1'b1, a, d, s, rd, ak, er);
    chk({tag, "_ack"}, {31'd0, ak}, 32'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic ak, er;
    bus(1'b0, a, 32'd0, 4'hF, rd, ak, er);
    chk({tag, "_ack"}, {31'd0, ak}, 32'd1);
    chk(tag, rd, exp);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    idle(2);
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic ak, er;
    int first_tick, last_tick, n_ticks;
    logic irq_k7, irq_k8;

    rst_i = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    adr_i = '0; dat_i = '0; sel_i = '0;
    idle(3);
    chk("rst_outs", {27'd0, ack_o, err_o, irq_o, tick_o, |dat_o}, 32'd0);
    rst_i = 1'b0;
    rd_chk("rst_ctrl",     32'h00, 32'h0);
    rd_chk("rst_prescale", 32'h04, 32'h0);
    rd_chk("rst_count",    32'h08, 32'h0);
    rd_chk("rst_compare",  32'h0C, 32'h0);
    rd_chk("rst_status",   32'h10, 32'h0);

    // Periodic: 2-cycle prescale, 4 ticks per match -> tick_o every 8 cycles.
    wr("per_pre", 32'h04, 32'd1, 4'hF);
    wr("per_cmp", 32'h0C, 32'd3, 4'hF);
    wr("per_ctrl", 32'h00, 32'h7, 4'hF);
    first_tick = -1; last_tick = -1; n_ticks = 0; irq_k7 = 1'bx; irq_k8 = 1'bx;
    for (int k = 1; k <= 26; k++) begin
      @(posedge clk_i); #1;
      if (tick_o === 1'b1) begin
        if (first_tick < 0) first_tick = k;
        last_tick = k;
        n_ticks++;
      end
      if (k == 7) irq_k7 = irq_o;
      if (k == 8) irq_k8 = irq_o;
    end
    chk("per_first_tick", first_tick, 32'd8);
    chk("per_last_tick",  last_tick,  32'd24);
    chk("per_n_ticks",    n_ticks,    32'd3);
    chk("per_irq_before", {31'd0, irq_k7}, 32'd0);
    chk("per_irq_match",  {31'd0, irq_k8}, 32'd1);
    wr("per_w1c", 32'h10, 32'h1, 4'h1);
    chk("per_irq_cleared", {31'd0, irq_o}, 32'd0);

    // One-shot.
    do_reset();
    wr("os_cmp", 32'h0C, 32'd2, 4'hF);
    wr("os_ctrl", 32'h00, 32'h5, 4'hF);
    first_tick = -1; n_ticks = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk_i); #1;
      if (tick_o === 1'b1) begin
        if (first_tick < 0) first_tick = k;
        n_ticks++;
      end
    end
    chk("os_n_ticks", n_ticks, 32'd1);
    chk("os_tick_at", first_tick, 32'd3);
    rd_chk("os_ctrl_rd",   32'h00, 32'h4);
    rd_chk("os_count_rd",  32'h08, 32'h0);
    rd_chk("os_status_rd", 32'h10, 32'h1);
    chk("os_irq", {31'd0, irq_o}, 32'd1);

    // Overflow: FFFFFFFE -> FFFFFFFF -> 0.
    do_reset();
    wr("ovf_count", 32'h08, 32'hFFFF_FFFE, 4'hF);
    wr("ovf_cmp",   32'h0C, 32'h10, 4'hF);
    wr("ovf_pre",   32'h04, 32'h0, 4'hF);
    wr("ovf_ctrl",  32'h00, 32'h9, 4'hF);
    idle(1);
    chk("ovf_irq_k1", {31'd0, irq_o}, 32'd0);
    idle(1);
    chk("ovf_irq_k2", {31'd0, irq_o}, 32'd1);
    rd_chk("ovf_count_rd",  32'h08, 32'h0);
    rd_chk("ovf_status_rd", 32'h10, 32'h2);

    // Collision: W1C on the first match edge, then COUNT write on a tick edge.
    do_reset();
    wr("col_cmp", 32'h0C, 32'd2, 4'hF);
    wr("col_ctrl", 32'h00, 32'h3, 4'hF);
    idle(2);
    wr("col_w1c", 32'h10, 32'h1, 4'h1);
    chk("col_tick", {31'd0, tick_o}, 32'd1);
    rd_chk("col_status_rd", 32'h10, 32'h1);
    wr("col_stop", 32'h00, 32'h0, 4'hF);
    wr("col_pre", 32'h04, 32'd4, 4'hF);
    wr("col_run", 32'h00, 32'h1, 4'hF);
    idle(4);
    wr("col_count", 32'h08, 32'h55, 4'hF);
    rd_chk("col_count_rd", 32'h08, 32'h55);

    // Bus behaviour.
    do_reset();
    bus(1'b0, 32'h14, 32'd0, 4'hF, rd, ak, er);
    chk("bus_err",      {31'd0, er}, 32'd1);
    chk("bus_err_ack",  {31'd0, ak}, 32'd0);
    chk("bus_err_dat",  rd, 32'h0);
    idle(1);
    chk("bus_err_drop", {31'd0, err_o}, 32'd0);
    wr("bus_cmp_sel", 32'h0C, 32'hAABB_CCDD, 4'h2);
    rd_chk("bus_cmp_rd", 32'h0C, 32'h0000_CC00);
    bus(1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF, rd, ak, er);
    chk("bus_unmapped_wr_err", {31'd0, er}, 32'd1);
    rd_chk("bus_ctrl_untouched", 32'h00, 32'h0);
    wr("bus_pre", 32'h04, 32'h1234_5678, 4'hF);
    rd_chk("bus_pre_rd", 32'h04, 32'h1234_5678);
    rst_i = 1'b1;
    idle(1);
    chk("bus_rst_outs", {27'd0, ack_o, err_o, irq_o, tick_o, |dat_o}, 32'd0);
    rst_i = 1'b0;
    rd_chk("bus_pre_after_rst", 32'h04, 32'h0);
    rd_chk("bus_cmp_after_rst", 32'h0C, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
